// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) types, constants and the xtime helper for the AES column engines.
// No ports. Optional forward-mode support is gated by the MIX_FWD_MODE_EN macro in users.
package aes_gf_pkg;

  typedef logic [7:0] gf_byte_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } imc_state_t;

  localparam gf_byte_t AES_RED_POLY = 8'h1B;

  localparam gf_byte_t C09 = 8'h09;
  localparam gf_byte_t C0B = 8'h0B;
  localparam gf_byte_t C0D = 8'h0D;
  localparam gf_byte_t C0E = 8'h0E;
  localparam gf_byte_t C02 = 8'h02;
  localparam gf_byte_t C03 = 8'h03;

  // Multiply by x modulo the AES polynomial.
  function automatic gf_byte_t xtime(input gf_byte_t a);
    gf_byte_t sh;
    sh = {a[6:0], 1'b0};
    return a[7] ? (sh ^ AES_RED_POLY) : sh;
  endfunction

endpackage

// File: rtl/gf_mul_imc_coeff.sv
// Constant GF(2^8) multiples of one byte, built from an xtime chain (x2, x4, x8).
// Ports: a_i - input byte; m09_o/m0b_o/m0d_o/m0e_o - InvMixColumns multiples;
//        m02_o/m03_o - MixColumns multiples (only when MIX_FWD_MODE_EN is defined).
module gf_mul_imc_coeff
  import aes_gf_pkg::*;
(
  input  gf_byte_t a_i,
  output gf_byte_t m09_o,
  output gf_byte_t m0b_o,
  output gf_byte_t m0d_o,
  output gf_byte_t m0e_o
`ifdef MIX_FWD_MODE_EN
  ,
  output gf_byte_t m02_o,
  output gf_byte_t m03_o
`endif
);

  gf_byte_t x2, x4, x8;

  assign x2 = xtime(a_i);
  assign x4 = xtime(x2);
  assign x8 = xtime(x4);

  assign m09_o = x8 ^ a_i;
  assign m0b_o = x8 ^ x2 ^ a_i;
  assign m0d_o = x8 ^ x4 ^ a_i;
  assign m0e_o = x8 ^ x4 ^ x2;

`ifdef MIX_FWD_MODE_EN
  assign m02_o = x2;
  assign m03_o = x2 ^ a_i;
`endif

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns engine: one 32-bit column in via valid/ready,
// one result byte per cycle over four cycles, result held until consumed.
// Ports: clk_i, rst_ni (sync active-low); col_i/valid_i/ready_o input handshake;
//        col_o/valid_o/ready_i output handshake; mode_i (1 = forward MixColumns)
//        exists only when MIX_FWD_MODE_EN is defined.
// Parameter OUT_REG: 1 = col_o from a dedicated output flop, 0 = straight from result bytes.
module inv_mix_columns_seq
  import aes_gf_pkg::*;
#(
  parameter int unsigned OUT_REG = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
`ifdef MIX_FWD_MODE_EN
  input  logic        mode_i,
`endif
  input  logic [31:0] col_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] col_o,
  output logic        valid_o,
  input  logic        ready_i
);

  imc_state_t  state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [31:0] col_q, col_d;
  gf_byte_t    res_q [4];
  gf_byte_t    res_d [4];
  logic        valid_q, ready_q;
`ifdef MIX_FWD_MODE_EN
  logic        mode_q, mode_d;
`endif

  // Latched column bytes, row 0 in the top byte.
  gf_byte_t a [4];
  assign a[0] = col_q[31:24];
  assign a[1] = col_q[23:16];
  assign a[2] = col_q[15:8];
  assign a[3] = col_q[7:0];

  gf_byte_t m09 [4];
  gf_byte_t m0b [4];
  gf_byte_t m0d [4];
  gf_byte_t m0e [4];
`ifdef MIX_FWD_MODE_EN
  gf_byte_t m02 [4];
  gf_byte_t m03 [4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_coeff
    gf_mul_imc_coeff u_coeff (
      .a_i   (a[g]),
      .m09_o (m09[g]),
      .m0b_o (m0b[g]),
      .m0d_o (m0d[g]),
      .m0e_o (m0e[g])
`ifdef MIX_FWD_MODE_EN
      ,
      .m02_o (m02[g]),
      .m03_o (m03[g])
`endif
    );
  end

  // Rotated byte positions relative to the current row (2-bit wrap gives mod 4).
  logic [1:0] rp1, rp2, rp3;
  assign rp1 = row_q + 2'd1;
  assign rp2 = row_q + 2'd2;
  assign rp3 = row_q + 2'd3;

  gf_byte_t out_byte_c;
  always_comb begin
    out_byte_c = m0e[row_q] ^ m0b[rp1] ^ m0d[rp2] ^ m09[rp3];
`ifdef MIX_FWD_MODE_EN
    if (mode_q) begin
      out_byte_c = m02[row_q] ^ m03[rp1] ^ a[rp2] ^ a[rp3];
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    res_d   = res_q;
`ifdef MIX_FWD_MODE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          col_d   = col_i;
          row_d   = 2'd0;
          state_d = COMPUTE;
`ifdef MIX_FWD_MODE_EN
          mode_d  = mode_i;
`endif
        end
      end
      COMPUTE: begin
        res_d[row_q] = out_byte_c;
        row_d        = row_q + 2'd1;
        if (row_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and handshake registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
      col_q   <= 32'h0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        res_q[i] <= '0;
      end
`ifdef MIX_FWD_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      res_q   <= res_d;
      valid_q <= (state_d == DONE);
      ready_q <= (state_d == IDLE);
`ifdef MIX_FWD_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign ready_o = ready_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic [31:0] out_q;
    // Capture the completed column on the same edge the last byte is written.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        out_q <= 32'h0;
      end else if (state_q == COMPUTE && row_q == 2'd3) begin
        out_q <= {res_d[0], res_d[1], res_d[2], res_d[3]};
      end
    end
    assign col_o = out_q;
  end else begin : g_out_comb
    assign col_o = {res_q[0], res_q[1], res_q[2], res_q[3]};
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
module tb_inv_mix_columns_seq;

  logic        clk;
  logic        rst_ni;
  logic [31:0] col_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] col_o;
  logic        valid_o;
  logic        ready_i;
`ifdef MIX_FWD_MODE_EN
  logic        mode_i;
`endif

  int errors;
  int checks;

  inv_mix_columns_seq #(.OUT_REG(1)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
`ifdef MIX_FWD_MODE_EN
    .mode_i  (mode_i),
`endif
    .col_i   (col_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .col_o   (col_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1B) : {t[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [31:0] mix_model(input logic [31:0] c, input bit fwd);
    logic [7:0] b [4];
    logic [7:0] k [4];
    logic [31:0] r;
    b[0] = c[31:24]; b[1] = c[23:16]; b[2] = c[15:8]; b[3] = c[7:0];
    if (fwd) begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end else begin
      k[0] = 8'h0E; k[1] = 8'h0B; k[2] = 8'h0D; k[3] = 8'h09;
    end
    r = 32'h0;
    for (int row = 0; row < 4; row++) begin
      logic [7:0] acc;
      acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(k[j], b[(row + j) % 4]);
      r = {r[23:0], acc};
    end
    return r;
  endfunction

  // Send one column, check latency and result against the model, then consume it.
  task automatic run_col(input logic [31:0] c, input bit fwd, output logic [31:0] got);
    int n;
    logic [31:0] exp;
    exp = mix_model(c, fwd);
    n = 0;
    while (!ready_o && n < 20) begin tick(); n++; end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL run_ready: ready_o=%b required 1", ready_o);
    end
    valid_i = 1'b1;
    col_i   = c;
`ifdef MIX_FWD_MODE_EN
    mode_i  = fwd;
`endif
    tick();
    valid_i = 1'b0;
    col_i   = $urandom;
`ifdef MIX_FWD_MODE_EN
    mode_i  = !fwd;
`endif
    n = 0;
    do begin tick(); n++; end while (!valid_o && n < 12);
    checks++;
    if (!(valid_o === 1'b1 && n == 4)) begin
      errors++; $display("FAIL latency: valid_o=%b after %0d edges required 1 after 4", valid_o, n);
    end
    checks++;
    if (col_o !== exp) begin
      errors++; $display("FAIL result: col_in=%08h col_o=%08h required %08h", c, col_o, exp);
    end
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL done_ready: ready_o=%b required 0", ready_o);
    end
    got = col_o;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || col_o !== exp) begin
      errors++;
      $display("FAIL after_hs: valid_o=%b ready_o=%b col_o=%08h required 0 1 %08h",
               valid_o, ready_o, col_o, exp);
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) tick();
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || col_o !== 32'h0) begin
      errors++;
      $display("FAIL reset: ready_o=%b valid_o=%b col_o=%08h required 1 0 00000000",
               ready_o, valid_o, col_o);
    end
    rst_ni = 1'b1;
    tick();
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL post_reset: ready_o=%b valid_o=%b required 1 0", ready_o, valid_o);
    end
  endtask

  task automatic test_vectors;
    logic [31:0] got;
    logic [31:0] cin [4];
    logic [31:0] cex [4];
    cin[0] = 32'h8E4DA1BC; cex[0] = 32'hDB135345;
    cin[1] = 32'h9FDC589D; cex[1] = 32'hF20A225C;
    cin[2] = 32'h01010101; cex[2] = 32'h01010101;
    cin[3] = 32'hC6C6C6C6; cex[3] = 32'hC6C6C6C6;
    for (int i = 0; i < 4; i++) begin
      run_col(cin[i], 1'b0, got);
      checks++;
      if (got !== cex[i]) begin
        errors++; $display("FAIL vector%0d: col_o=%08h required %08h", i, got, cex[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] got;
    for (int i = 0; i < 12; i++) run_col($urandom, 1'b0, got);
  endtask

  task automatic test_backpressure;
    int n;
    logic [31:0] c, exp, got;
    c = $urandom;
    exp = mix_model(c, 1'b0);
    valid_i = 1'b1; col_i = c;
`ifdef MIX_FWD_MODE_EN
    mode_i = 1'b0;
`endif
    tick();
    valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 12) begin tick(); n++; end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (valid_o !== 1'b1 || col_o !== exp || ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid_o=%b col_o=%08h ready_o=%b required 1 %08h 0",
                 k, valid_o, col_o, ready_o, exp);
      end
      valid_i = (k == 3);
      col_i   = 32'hFFFFFFFF;
      tick();
      valid_i = 1'b0;
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || col_o !== exp) begin
      errors++;
      $display("FAIL bp_release: valid_o=%b ready_o=%b col_o=%08h required 0 1 %08h",
               valid_o, ready_o, col_o, exp);
    end
    run_col(32'h8E4DA1BC, 1'b0, got);
    checks++;
    if (got !== 32'hDB135345) begin
      errors++; $display("FAIL bp_next: col_o=%08h required DB135345", got);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q [$];
    logic [31:0] exp;
    int outs;
    logic prev_v;
    outs = 0;
    prev_v = 1'b0;
    ready_i = 1'b1;
    valid_i = 1'b1;
`ifdef MIX_FWD_MODE_EN
    mode_i = 1'b0;
`endif
    for (int t = 0; t < 75; t++) begin
      col_i = $urandom;
      if (t >= 60) valid_i = 1'b0;
      if (valid_o) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious: valid_o=1 with no column outstanding");
        end else begin
          exp = q.pop_front();
          if (col_o !== exp || prev_v) begin
            errors++;
            $display("FAIL b2b_out: col_o=%08h prev_valid=%b required %08h 0", col_o, prev_v, exp);
          end
        end
        outs++;
      end
      prev_v = valid_o;
      if (ready_o && valid_i) q.push_back(mix_model(col_i, 1'b0));
      tick();
    end
    ready_i = 1'b0;
    checks++;
    if (q.size() != 0 || outs != 10) begin
      errors++; $display("FAIL b2b_count: outputs=%0d pending=%0d required 10 0", outs, q.size());
    end
  endtask

  task automatic test_reset_midop;
    int spurious;
    valid_i = 1'b1; col_i = $urandom;
`ifdef MIX_FWD_MODE_EN
    mode_i = 1'b0;
`endif
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || col_o !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset: ready_o=%b valid_o=%b col_o=%08h required 1 0 00000000",
               ready_o, valid_o, col_o);
    end
    spurious = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (valid_o) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++; $display("FAIL midop_spurious: valid_o high %0d cycles required 0", spurious);
    end
  endtask

`ifdef MIX_FWD_MODE_EN
  task automatic test_fwd_mode;
    logic [31:0] got;
    run_col(32'hDB135345, 1'b1, got);
    checks++;
    if (got !== 32'h8E4DA1BC) begin
      errors++; $display("FAIL fwd1: col_o=%08h required 8E4DA1BC", got);
    end
    run_col(32'hD4D4D4D5, 1'b1, got);
    checks++;
    if (got !== 32'hD5D5D7D6) begin
      errors++; $display("FAIL fwd2: col_o=%08h required D5D5D7D6", got);
    end
    run_col(32'h8E4DA1BC, 1'b0, got);
    checks++;
    if (got !== 32'hDB135345) begin
      errors++; $display("FAIL fwd_inv: col_o=%08h required DB135345", got);
    end
    for (int i = 0; i < 6; i++) run_col($urandom, 1'($urandom_range(0, 1)), got);
  endtask
`endif

  initial begin
    errors  = 0;
    checks  = 0;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    col_i   = 32'h0;
`ifdef MIX_FWD_MODE_EN
    mode_i  = 1'b0;
`endif
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
`ifdef MIX_FWD_MODE_EN
    test_fwd_mode();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
